// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair: default widths,
// duty resolution and the capture FSM state encoding.
package pwm_pkg;

  localparam int CNT_BITS_DEF = 16;

  // Duty resolution in bits, common to the generator and capture benches
  localparam int DUTY_RES = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer followed by a previous-value register; produces the
// synchronized level and single-cycle rise/fall strobes with equal latency.
module pwm_edge_sync
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Flops clear to 0, so a line already high at release yields a rise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign level = r_sync;
  assign rise  = r_sync & ~r_prev;
  assign fall  = ~r_sync & r_prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an asynchronous PWM input in
// clk cycles, and flags a line with no rise for TIMEOUT cycles.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_BITS = CNT_BITS_DEF,
  parameter int TIMEOUT  = 2**CNT_BITS - 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pwm_in,
  output logic [CNT_BITS-1:0] high_cnt,
  output logic [CNT_BITS-1:0] period_cnt,
  output logic                meas_valid,
  output logic                timeout,
  output logic                stuck_level
);

  localparam logic [CNT_BITS-1:0] TIMEOUT_C = CNT_BITS'(TIMEOUT);
  localparam logic [CNT_BITS-1:0] ONE_C     = CNT_BITS'(1);

  logic w_level;
  logic w_rise;
  logic w_fall;

  pwm_edge_sync u_edge_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (pwm_in),
    .level    (w_level),
    .rise     (w_rise),
    .fall     (w_fall)
  );

  cap_state_e          r_state;
  cap_state_e          w_state_nxt;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] r_high_lat;
  logic [CNT_BITS-1:0] r_high;
  logic [CNT_BITS-1:0] r_period;
  logic                r_valid;
  logic                r_timeout;
  logic                r_stuck;

  logic w_sat;
  logic w_tmo_hit;
  logic w_report;
  logic w_latch_high;
  logic w_tmo;

  assign w_sat     = &r_cnt;
  // An edge in the same cycle always takes priority over the timeout
  assign w_tmo_hit = (r_cnt == TIMEOUT_C) && !w_rise && !w_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_report     = 1'b0;
    w_latch_high = 1'b0;
    w_tmo        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (w_fall) begin
          w_latch_high = 1'b1;
          w_state_nxt  = ST_LOW;
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (w_rise) begin
          w_report    = 1'b1;
          w_state_nxt = ST_HIGH;
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Cycles since the last rise; saturates rather than wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= ONE_C;
    end else if (!w_sat) begin
      r_cnt <= r_cnt + ONE_C;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_high_lat <= '0;
    end else if (w_latch_high) begin
      r_high_lat <= r_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_high    <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_stuck   <= 1'b0;
    end else begin
      r_valid <= w_report;
      if (w_report) begin
        r_high    <= r_high_lat;
        r_period  <= r_cnt;
        r_timeout <= 1'b0;
      end else if (w_tmo) begin
        r_timeout <= 1'b1;
        r_stuck   <= w_level;
      end
    end
  end

  assign high_cnt    = r_high;
  assign period_cnt  = r_period;
  assign meas_valid  = r_valid;
  assign timeout     = r_timeout;
  assign stuck_level = r_stuck;

endmodule
